// File: rtl/i2c_pkg.sv
// Shared I2C bit-level definitions: command encodings (common to the bit
// reader and bit writer) and the bit-reader state type.
package i2c_pkg;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        READ_DATA = 2'b01,
        READ_ACK  = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        LOW1,
        LOW2,
        HIGH1,
        HIGH2,
        DONE,
        WAIT_REL
    } state_e;

    function automatic logic cmd_valid(input logic [1:0] c);
        return (c == READ_DATA) || (c == READ_ACK);
    endfunction

endpackage

// File: rtl/i2c_read_bit_if.sv
// Command handshake and bus pins of the I2C bit reader. The controller side
// (master) drives command/go and the line readbacks; the reader is the slave.
interface i2c_read_bit_if;
    logic [1:0] command;
    logic       go;
    logic       finish;
    logic       bit_out;
    logic       ack;
    logic       error;
    logic       scl;
    logic       sda;
    logic       scl_in;
    logic       sda_in;

    modport master (
        output command, go, scl_in, sda_in,
        input  finish, bit_out, ack, error, scl, sda
    );

    modport slave (
        input  command, go, scl_in, sda_in,
        output finish, bit_out, ack, error, scl, sda
    );
endinterface

// File: rtl/i2c_phase_timer.sv
// SCL quarter-phase prescaler: phase_done pulses every PHASE_CYCLES cycles,
// restarts on clear and holds its count while freeze is high.
module i2c_phase_timer #(
    parameter int PHASE_CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic freeze,
    output logic phase_done
);
    localparam int W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(PHASE_CYCLES - 1);

    logic [W-1:0] cnt;

    assign phase_done = ~freeze & (cnt == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear || phase_done)
            cnt <= '0;
        else if (!freeze)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/i2c_read_bit.sv
// I2C master bit receiver: one SCL pulse with SDA released, samples SDA twice
// while SCL is high. Optional slave clock stretching via I2C_CLOCK_STRETCH_EN.
module i2c_read_bit
    import i2c_pkg::*;
#(
    parameter int PHASE_CYCLES = 1,
    parameter int STRETCH_MAX  = 255
) (
    input  logic           clock,
    input  logic           reset,
    i2c_read_bit_if.slave  bus
);
    localparam int SW = $clog2(STRETCH_MAX + 2);

    state_e     state_q, state_d;
    logic [1:0] cmd_q, cmd_d;
    logic       a_q, a_d;
    logic       fin_q, fin_d;
    logic       bit_q, bit_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic       scl_q, scl_d;
    logic       phase_done;
    logic       stretch_hold;
    logic       timeout;

`ifdef I2C_CLOCK_STRETCH_EN
    logic [SW-1:0] stretch_cnt;

    // Slave holding SCL low during HIGH1 pauses the phase timer.
    assign stretch_hold = (state_q == HIGH1) & ~bus.scl_in;
    assign timeout      = (state_q == HIGH1) & (stretch_cnt > SW'(STRETCH_MAX));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stretch_cnt <= '0;
        else if (state_q != HIGH1)
            stretch_cnt <= '0;
        else if (stretch_hold)
            stretch_cnt <= stretch_cnt + 1'b1;
    end
`else
    logic unused_stretch;

    // scl_in and STRETCH_MAX only feed the stretch logic.
    assign unused_stretch = ^{bus.scl_in, SW'(STRETCH_MAX)};
    assign stretch_hold   = 1'b0;
    assign timeout        = 1'b0;
`endif

    i2c_phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (state_d != state_q),
        .freeze     (stretch_hold),
        .phase_done (phase_done)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cmd_q   <= 2'b00;
            a_q     <= 1'b0;
            fin_q   <= 1'b0;
            bit_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            scl_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            a_q     <= a_d;
            fin_q   <= fin_d;
            bit_q   <= bit_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            scl_q   <= scl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        a_d     = a_q;
        fin_d   = 1'b0;
        bit_d   = bit_q;
        ack_d   = ack_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.go && cmd_valid(bus.command)) begin
                cmd_d   = bus.command;
                state_d = LOW1;
            end
            LOW1: if (phase_done) state_d = LOW2;
            LOW2: if (phase_done) state_d = HIGH1;
            HIGH1: begin
                if (timeout) begin
                    fin_d   = 1'b1;
                    bit_d   = 1'b1;
                    ack_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (phase_done) begin
                    a_d     = bus.sda_in;
                    state_d = HIGH2;
                end
            end
            HIGH2: if (phase_done) begin
                // A change between the two samples means a START/STOP on the bus.
                fin_d   = 1'b1;
                bit_d   = bus.sda_in;
                ack_d   = (cmd_q == READ_ACK) & ~bus.sda_in;
                err_d   = a_q ^ bus.sda_in;
                state_d = DONE;
            end
            DONE:     state_d = bus.go ? WAIT_REL : IDLE;
            WAIT_REL: if (!bus.go) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        scl_d = !((state_d == LOW1) || (state_d == LOW2));
    end

    assign bus.finish  = fin_q;
    assign bus.bit_out = bit_q;
    assign bus.ack     = ack_q;
    assign bus.error   = err_q;
    assign bus.scl     = scl_q;
    assign bus.sda     = 1'b1;
endmodule
